// File: rtl/cc_useq_pkg.sv
// Shared constants for the microsequencer: branch condition codes, PSR flag
// positions and the instruction-register fields used by DECODE and JIR13.
package cc_useq_pkg;

  localparam int COND_NEXT   = 0;
  localparam int COND_JN     = 1;
  localparam int COND_JZ     = 2;
  localparam int COND_JV     = 3;
  localparam int COND_JC     = 4;
  localparam int COND_JIR13  = 5;
  localparam int COND_JMP    = 6;
  localparam int COND_DECODE = 7;
  localparam int COND_CALL   = 8;
  localparam int COND_RET    = 9;

  // PSR is packed {n,z,v,c}, so n is the most significant bit
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  localparam int IR_OP_HI  = 31;
  localparam int IR_OP_LO  = 30;
  localparam int IR_OP3_HI = 24;
  localparam int IR_OP3_LO = 19;
  localparam int IR_BIT13  = 13;

endpackage

// File: rtl/cc_useq_stack.sv
// Bounded LIFO of return microaddresses. A single pointer counts the stored
// entries; push and pop never occur together.
module cc_useq_stack #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]     sp;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     top_idx;
  logic [ADDR_W-1:0] mem [DEPTH];

  assign full    = (sp == PW'(DEPTH));
  assign empty   = (sp == '0);
  assign wr_idx  = IW'(sp);
  assign top_idx = IW'(sp - PW'(1));
  assign pop_data = mem[top_idx];

  // Only the pointer is reset; stale entries are unreachable once sp is 0
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + PW'(1);
    end else if (pop && !empty) begin
      sp <= sp - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !rst) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/cc_microsequencer.sv
// Control-store address sequencer: incrementer, condition branches, PSR,
// memory-ACK stalling and a bounded CALL/RET return stack.
module cc_microsequencer
  import cc_useq_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int COND_W      = 4,
  parameter int STACK_DEPTH = 4,
  parameter int FLAG_W      = 4
) (
  input  logic              CLOCK_50,
  input  logic              RESET_InHigh,
  input  logic [COND_W-1:0] mir_cond,
  input  logic [ADDR_W-1:0] mir_jump_addr,
  input  logic              mir_rd,
  input  logic              mir_wr,
  input  logic              mem_ack,
  input  logic [31:0]       ir,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic              set_cc,
  output logic [ADDR_W-1:0] csa_addr,
  output logic [FLAG_W-1:0] psr_flags,
  output logic              stall,
  output logic              stack_ovf,
  output logic              stack_unf
);

  logic [ADDR_W-1:0] inc_addr;
  logic [ADDR_W-1:0] decode_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] ret_addr;
  logic              stk_full;
  logic              stk_empty;
  logic              is_call;
  logic              is_ret;
  logic              push;
  logic              pop;
  logic              unused_ir_bits;

  assign stall    = (mir_rd | mir_wr) & ~mem_ack;
  assign inc_addr = csa_addr + ADDR_W'(1);
  assign decode_addr = ADDR_W'({1'b1, ir[IR_OP_HI:IR_OP_LO],
                                ir[IR_OP3_HI:IR_OP3_LO], 2'b00});
  assign unused_ir_bits = ^{ir[29:25], ir[18:14], ir[12:0]};

  assign is_call = (mir_cond == COND_W'(COND_CALL));
  assign is_ret  = (mir_cond == COND_W'(COND_RET));
  assign push    = is_call & ~stall & ~stk_full;
  assign pop     = is_ret & ~stall & ~stk_empty;

  // Flag branches look at the registered PSR, so a same-cycle set_cc is not seen
  always_comb begin
    next_addr = inc_addr;
    case (mir_cond)
      COND_W'(COND_JN):     if (psr_flags[FLAG_N]) next_addr = mir_jump_addr;
      COND_W'(COND_JZ):     if (psr_flags[FLAG_Z]) next_addr = mir_jump_addr;
      COND_W'(COND_JV):     if (psr_flags[FLAG_V]) next_addr = mir_jump_addr;
      COND_W'(COND_JC):     if (psr_flags[FLAG_C]) next_addr = mir_jump_addr;
      COND_W'(COND_JIR13):  if (ir[IR_BIT13])      next_addr = mir_jump_addr;
      COND_W'(COND_JMP):    next_addr = mir_jump_addr;
      COND_W'(COND_DECODE): next_addr = decode_addr;
      COND_W'(COND_CALL):   next_addr = mir_jump_addr;
      COND_W'(COND_RET):    next_addr = stk_empty ? mir_jump_addr : ret_addr;
      default:              next_addr = inc_addr;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET_InHigh) begin
      csa_addr  <= '0;
      psr_flags <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else if (!stall) begin
      csa_addr <= next_addr;
      if (set_cc)              psr_flags <= alu_flags;
      if (is_call && stk_full) stack_ovf <= 1'b1;
      if (is_ret && stk_empty) stack_unf <= 1'b1;
    end
  end

  cc_useq_stack #(
    .DEPTH  (STACK_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_stack (
    .clk       (CLOCK_50),
    .rst       (RESET_InHigh),
    .push      (push),
    .pop       (pop),
    .push_data (inc_addr),
    .pop_data  (ret_addr),
    .full      (stk_full),
    .empty     (stk_empty)
  );

endmodule
